// File: rtl/io_uart_bridge.sv
// io_uart_bridge: IO port bus to byte-wide UART bridge with TX/RX FIFOs, paced TX handshake and sticky error status
module io_uart_bridge #(
    parameter int         FIFO_DEPTH    = 16,
    parameter int         TX_GAP_CYCLES = 2,
    parameter logic [7:0] DATA_PORT     = 8'h01,
    parameter logic [7:0] RXSTAT_PORT   = 8'h02,
    parameter logic [7:0] TXSTAT_PORT   = 8'h03,
    parameter logic [7:0] ERR_PORT      = 8'h04
) (
    input  logic       clk100,
    input  logic       reset,
    input  logic [7:0] IO_port_ID,
    input  logic [7:0] IO_write_data,
    input  logic       IO_write_strobe,
    input  logic       IO_read_strobe,
    output logic [7:0] IO_read_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    output logic       irq_rx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(TX_GAP_CYCLES + 2);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_t;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          wr_prev, rd_prev;
    logic [7:0]    rd_port;
    logic          rx_overrun, tx_overflow, rx_underflow;
    tx_state_t     state, state_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic          tx_pop, tx_load;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          wr_first, rd_fall, tx_req, tx_push, rd_data, rx_pop, rx_push, err_clr;

    assign tx_full  = tx_cnt == FULL;
    assign tx_empty = tx_cnt == '0;
    assign rx_full  = rx_cnt == FULL;
    assign rx_empty = rx_cnt == '0;
    assign wr_first = IO_write_strobe && !wr_prev;
    assign rd_fall  = !IO_read_strobe && rd_prev;
    assign tx_req   = wr_first && IO_port_ID == DATA_PORT;
    assign tx_push  = tx_req && !tx_full;
    assign rd_data  = rd_fall && rd_port == DATA_PORT;
    assign rx_pop   = rd_data && !rx_empty;
    assign rx_push  = rx_strobe && (!rx_full || rx_pop);
    assign err_clr  = rd_fall && rd_port == ERR_PORT;
    assign tx_valid = state == TX_SEND && !reset;

    assign IO_read_data = !IO_read_strobe            ? 8'h00 :
                          IO_port_ID == DATA_PORT   ? (rx_empty ? 8'h00 : rx_mem[rx_rd]) :
                          IO_port_ID == RXSTAT_PORT ? {8{!rx_empty}} :
                          IO_port_ID == TXSTAT_PORT ? {8{tx_full}} :
                          IO_port_ID == ERR_PORT    ? {5'b0, rx_overrun, tx_overflow, rx_underflow} :
                                                      8'hFF;

    // Strobe history for edge detection; read port is latched so side effects at strobe fall use it
    always_ff @(posedge clk100) begin
        if (reset) begin
            wr_prev <= 1'b0;
            rd_prev <= 1'b0;
            rd_port <= 8'h00;
        end else begin
            wr_prev <= IO_write_strobe;
            rd_prev <= IO_read_strobe;
            if (IO_read_strobe && !rd_prev)
                rd_port <= IO_port_ID;
        end
    end

    // FIFO storage needs no reset; emptiness is defined by the pointers and counts
    always_ff @(posedge clk100) begin
        if (tx_push)
            tx_mem[tx_wr] <= IO_write_data;
        if (rx_push)
            rx_mem[rx_wr] <= rx_data;
    end

    // FIFO pointers wrap naturally at the power-of-two depth; counts track occupancy
    always_ff @(posedge clk100) begin
        if (reset) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            tx_wr  <= tx_wr + AW'(tx_push);
            tx_rd  <= tx_rd + AW'(tx_pop);
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            rx_wr  <= rx_wr + AW'(rx_push);
            rx_rd  <= rx_rd + AW'(rx_pop);
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // Sticky error bits; a new error event beats a clear in the same cycle
    always_ff @(posedge clk100) begin
        if (reset) begin
            rx_overrun   <= 1'b0;
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
            irq_rx       <= 1'b0;
        end else begin
            rx_overrun   <= (rx_overrun && !err_clr) || (rx_strobe && rx_full && !rx_pop);
            tx_overflow  <= (tx_overflow && !err_clr) || (tx_req && tx_full);
            rx_underflow <= (rx_underflow && !err_clr) || (rd_data && rx_empty);
            irq_rx       <= !rx_empty;
        end
    end

    // TX state register; the presented byte is captured once on entry to TX_SEND
    always_ff @(posedge clk100) begin
        if (reset) begin
            state   <= TX_IDLE;
            gap_cnt <= '0;
            tx_data <= 8'h00;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_n;
            if (tx_load)
                tx_data <= tx_mem[tx_rd];
        end
    end

    // TX sequencing: present head, wait for handshake, then hold off for the gap
    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        tx_pop  = 1'b0;
        tx_load = 1'b0;
        case (state)
            TX_IDLE: if (!tx_empty) begin
                state_n = TX_SEND;
                tx_load = 1'b1;
            end
            TX_SEND: if (tx_ready) begin
                tx_pop  = 1'b1;
                gap_n   = '0;
                state_n = TX_GAP_CYCLES > 0 ? TX_GAP : TX_IDLE;
            end
            TX_GAP: if (gap_cnt == GW'(TX_GAP_CYCLES - 1))
                state_n = TX_IDLE;
            else
                gap_n = gap_cnt + 1'b1;
            default: state_n = TX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_io_uart_bridge.sv
// tb_io_uart_bridge: randomized and directed checks of io_uart_bridge against a queue-based port model
module tb_io_uart_bridge;
    localparam int         DEPTH = 16;
    localparam int         GAP   = 2;
    localparam logic [7:0] P_DATA = 8'h01, P_RXS = 8'h02, P_TXS = 8'h03, P_ERR = 8'h04;

    logic       clk100 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] IO_port_ID = 8'h00;
    logic [7:0] IO_write_data = 8'h00;
    logic       IO_write_strobe = 1'b0;
    logic       IO_read_strobe = 1'b0;
    logic [7:0] IO_read_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_strobe = 1'b0;
    logic       irq_rx;

    io_uart_bridge #(.FIFO_DEPTH(DEPTH), .TX_GAP_CYCLES(GAP)) dut (
        .clk100(clk100), .reset(reset),
        .IO_port_ID(IO_port_ID), .IO_write_data(IO_write_data),
        .IO_write_strobe(IO_write_strobe), .IO_read_strobe(IO_read_strobe),
        .IO_read_data(IO_read_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_strobe(rx_strobe), .irq_rx(irq_rx)
    );

    always #5 clk100 = ~clk100;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         tx_acc = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] tx_obs[$];
    logic [7:0] rx_q[$];
    int         hs_cyc[$];
    logic [2:0] err_m = 3'b000;

    // Handshake monitor: inputs change at the falling edge, so valid&&ready here predicts the next rising edge
    always begin
        @(negedge clk100);
        #2;
        cyc++;
        if (tx_valid && tx_ready) begin
            tx_obs.push_back(tx_data);
            hs_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] exp_read(input logic [7:0] p);
        if (p == P_DATA) begin
            if (rx_q.size() > 0) return rx_q[0];
            return 8'h00;
        end
        if (p == P_RXS) return rx_q.size() > 0 ? 8'hFF : 8'h00;
        if (p == P_TXS) return (tx_acc - tx_obs.size()) == DEPTH ? 8'hFF : 8'h00;
        if (p == P_ERR) return {5'b0, err_m};
        return 8'hFF;
    endfunction

    task automatic do_reset();
        @(negedge clk100);
        reset = 1'b1;
        IO_write_strobe = 1'b0;
        IO_read_strobe = 1'b0;
        rx_strobe = 1'b0;
        tx_ready = 1'b0;
        @(negedge clk100);
        @(negedge clk100);
        reset = 1'b0;
        tx_exp.delete();
        tx_obs.delete();
        hs_cyc.delete();
        rx_q.delete();
        err_m = 3'b000;
        tx_acc = 0;
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] data, input int hold);
        @(negedge clk100);
        IO_port_ID = port;
        IO_write_data = data;
        IO_write_strobe = 1'b1;
        if (port == P_DATA) begin
            if (tx_acc - tx_obs.size() < DEPTH) begin
                tx_exp.push_back(data);
                tx_acc++;
            end else
                err_m[1] = 1'b1;
        end
        repeat (hold - 1) @(negedge clk100);
        @(negedge clk100);
        IO_write_strobe = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] port, input int hold, output logic [7:0] v, output bit stable);
        @(negedge clk100);
        IO_port_ID = port;
        IO_read_strobe = 1'b1;
        #1;
        v = IO_read_data;
        stable = 1'b1;
        repeat (hold - 1) begin
            @(negedge clk100);
            #1;
            if (IO_read_data !== v) stable = 1'b0;
        end
        @(negedge clk100);
        IO_read_strobe = 1'b0;
        if (port == P_DATA) begin
            if (rx_q.size() > 0) void'(rx_q.pop_front());
            else err_m[0] = 1'b1;
        end else if (port == P_ERR)
            err_m = 3'b000;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        @(negedge clk100);
        rx_data = d;
        rx_strobe = 1'b1;
        if (rx_q.size() < DEPTH) rx_q.push_back(d);
        else err_m[2] = 1'b1;
        @(negedge clk100);
        rx_strobe = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int budget);
        for (int i = 0; i < budget && tx_obs.size() < n; i++) @(negedge clk100);
    endtask

    task automatic test_reset();
        logic [7:0] p[4];
        logic [7:0] w[4];
        logic [7:0] v;
        bit s;
        p = '{8'h02, 8'h03, 8'h04, 8'h77};
        w = '{8'h00, 8'h00, 8'h00, 8'hFF};
        do_reset();
        @(negedge clk100);
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        total++; if (irq_rx !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq_rx); end
        total++; if (IO_read_data !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", IO_read_data); end
        for (int i = 0; i < 4; i++) begin
            io_read(p[i], 1, v, s);
            total++; if (v !== w[i]) begin bad++; $display("FAIL reset_port_%h: got %h want %h", p[i], v, w[i]); end
        end
        #1;
        total++; if (IO_read_data !== 8'h00) begin bad++; $display("FAIL idle_rdata: got %h want 00", IO_read_data); end
    endtask

    task automatic test_tx_order();
        do_reset();
        tx_ready = 1'b1;
        io_write(P_DATA, 8'h41, 1);
        io_write(P_DATA, 8'h42, 1);
        wait_tx(2, 60);
        total++; if (tx_obs.size() != 2) begin bad++; $display("FAIL tx_order_count: got %0d want 2", tx_obs.size()); end
        for (int i = 0; i < tx_obs.size() && i < 2; i++) begin
            total++; if (tx_obs[i] !== tx_exp[i]) begin bad++; $display("FAIL tx_order_byte%0d: got %h want %h", i, tx_obs[i], tx_exp[i]); end
        end
        if (hs_cyc.size() >= 2) begin
            total++; if (hs_cyc[1] - hs_cyc[0] != GAP + 2) begin bad++; $display("FAIL tx_spacing: got %0d want %0d", hs_cyc[1] - hs_cyc[0], GAP + 2); end
        end
    endtask

    task automatic test_write_hold();
        do_reset();
        tx_ready = 1'b1;
        io_write(P_DATA, 8'h55, 5);
        repeat (30) @(negedge clk100);
        total++; if (tx_obs.size() != 1) begin bad++; $display("FAIL hold_count: got %0d want 1", tx_obs.size()); end
        if (tx_obs.size() > 0) begin
            total++; if (tx_obs[0] !== 8'h55) begin bad++; $display("FAIL hold_byte: got %h want 55", tx_obs[0]); end
        end
    endtask

    task automatic test_tx_full();
        logic [7:0] v;
        logic [7:0] e;
        bit s;
        do_reset();
        for (int i = 0; i < DEPTH; i++) io_write(P_DATA, 8'(8'h10 + i), 1);
        e = exp_read(P_TXS);
        io_read(P_TXS, 1, v, s);
        total++; if (v !== e || v !== 8'hFF) begin bad++; $display("FAIL txfull_stat: got %h want %h", v, e); end
        io_write(P_DATA, 8'hEE, 1);
        e = exp_read(P_ERR);
        io_read(P_ERR, 1, v, s);
        total++; if (v !== e || v !== 8'h02) begin bad++; $display("FAIL overflow_err: got %h want %h", v, e); end
        io_read(P_ERR, 1, v, s);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL err_clear: got %h want 00", v); end
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin bad++; $display("FAIL tx_held: got %b/%h want 1/10", tx_valid, tx_data); end
        tx_ready = 1'b1;
        wait_tx(DEPTH, 200);
        total++; if (tx_obs.size() != DEPTH) begin bad++; $display("FAIL drain_count: got %0d want %0d", tx_obs.size(), DEPTH); end
        for (int i = 0; i < tx_obs.size() && i < DEPTH; i++) begin
            total++; if (tx_obs[i] !== tx_exp[i]) begin bad++; $display("FAIL drain_byte%0d: got %h want %h", i, tx_obs[i], tx_exp[i]); end
        end
        for (int i = 1; i < hs_cyc.size(); i++) begin
            total++; if (hs_cyc[i] - hs_cyc[i-1] != GAP + 2) begin bad++; $display("FAIL drain_spacing%0d: got %0d want %0d", i, hs_cyc[i] - hs_cyc[i-1], GAP + 2); end
        end
    endtask

    task automatic test_rx();
        logic [7:0] v;
        bit s;
        do_reset();
        rx_pulse(8'hA5);
        @(negedge clk100);
        #1;
        total++; if (irq_rx !== 1'b1) begin bad++; $display("FAIL rx_irq_set: got %b want 1", irq_rx); end
        io_read(P_RXS, 1, v, s);
        total++; if (v !== 8'hFF) begin bad++; $display("FAIL rx_stat_full: got %h want FF", v); end
        io_read(P_DATA, 3, v, s);
        total++; if (v !== 8'hA5) begin bad++; $display("FAIL rx_data: got %h want A5", v); end
        total++; if (s !== 1'b1) begin bad++; $display("FAIL rx_data_stable: got %b want 1", s); end
        io_read(P_RXS, 1, v, s);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL rx_stat_empty: got %h want 00", v); end
        #1;
        total++; if (irq_rx !== 1'b0) begin bad++; $display("FAIL rx_irq_clear: got %b want 0", irq_rx); end
    endtask

    task automatic test_errors();
        logic [7:0] v;
        logic [7:0] e;
        bit s;
        do_reset();
        io_read(P_DATA, 1, v, s);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL underflow_data: got %h want 00", v); end
        io_read(P_ERR, 1, v, s);
        total++; if (v !== 8'h01) begin bad++; $display("FAIL underflow_err: got %h want 01", v); end
        for (int i = 0; i < DEPTH + 1; i++) rx_pulse(8'($urandom));
        e = exp_read(P_ERR);
        io_read(P_ERR, 1, v, s);
        total++; if (v !== e || v !== 8'h04) begin bad++; $display("FAIL overrun_err: got %h want %h", v, e); end
        e = exp_read(P_DATA);
        io_read(P_DATA, 1, v, s);
        total++; if (v !== e) begin bad++; $display("FAIL overrun_head: got %h want %h", v, e); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        bit s;
        do_reset();
        io_write(P_DATA, 8'($urandom), 1);
        for (int i = 0; i < 10 && !tx_valid; i++) @(negedge clk100);
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL mid_valid_up: got %b want 1", tx_valid); end
        @(negedge clk100);
        reset = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk100);
        reset = 1'b0;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid_valid_down: got %b want 0", tx_valid); end
        total++; if (tx_obs.size() != 0) begin bad++; $display("FAIL mid_no_handshake: got %0d want 0", tx_obs.size()); end
        tx_exp.delete();
        tx_obs.delete();
        hs_cyc.delete();
        rx_q.delete();
        err_m = 3'b000;
        tx_acc = 0;
        io_read(P_RXS, 1, v, s);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL mid_rx_empty: got %h want 00", v); end
        io_read(P_TXS, 1, v, s);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL mid_tx_notfull: got %h want 00", v); end
        repeat (10) @(negedge clk100);
        total++; if (tx_obs.size() != 0 || tx_valid !== 1'b0) begin bad++; $display("FAIL mid_tx_empty: got %0d/%b want 0/0", tx_obs.size(), tx_valid); end
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic [7:0] e;
        logic [7:0] p;
        bit s;
        int op;
        int h;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk100);
            tx_ready = $urandom_range(0, 3) == 0;
            @(negedge clk100);
            #3;
            total++; if (irq_rx !== (rx_q.size() > 0)) begin bad++; $display("FAIL rnd_irq%0d: got %b want %b", n, irq_rx, rx_q.size() > 0); end
            total++; if (IO_read_data !== 8'h00) begin bad++; $display("FAIL rnd_idle%0d: got %h want 00", n, IO_read_data); end
            op = $urandom_range(0, 7);
            case (op)
                0, 1: io_write(P_DATA, 8'($urandom), $urandom_range(1, 3));
                2: io_write(8'(8'h05 + $urandom_range(0, 100)), 8'($urandom), 1);
                3, 4: rx_pulse(8'($urandom));
                5: begin
                    h = $urandom_range(1, 2);
                    e = exp_read(P_DATA);
                    io_read(P_DATA, h, v, s);
                    total++; if (v !== e || !s) begin bad++; $display("FAIL rnd_data%0d: got %h stable=%b want %h", n, v, s, e); end
                end
                6: begin
                    h = $urandom_range(0, 3);
                    p = h == 3 ? 8'(8'h05 + $urandom_range(0, 200)) : 8'(P_RXS + h);
                    e = exp_read(p);
                    io_read(p, 1, v, s);
                    total++; if (v !== e) begin bad++; $display("FAIL rnd_port%0d_%h: got %h want %h", n, p, v, e); end
                end
                default: @(negedge clk100);
            endcase
        end
        @(negedge clk100);
        tx_ready = 1'b1;
        wait_tx(tx_exp.size(), 400);
        total++; if (tx_obs.size() != tx_exp.size()) begin bad++; $display("FAIL rnd_tx_count: got %0d want %0d", tx_obs.size(), tx_exp.size()); end
        for (int i = 0; i < tx_obs.size() && i < tx_exp.size(); i++) begin
            total++; if (tx_obs[i] !== tx_exp[i]) begin bad++; $display("FAIL rnd_tx_byte%0d: got %h want %h", i, tx_obs[i], tx_exp[i]); end
        end
        for (int i = 1; i < hs_cyc.size(); i++) begin
            total++; if (hs_cyc[i] - hs_cyc[i-1] < GAP + 2) begin bad++; $display("FAIL rnd_spacing%0d: got %0d want >=%0d", i, hs_cyc[i] - hs_cyc[i-1], GAP + 2); end
        end
    endtask

    initial begin
        test_reset();
        test_tx_order();
        test_write_hold();
        test_tx_full();
        test_rx();
        test_errors();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/io_uart_bridge.md
Name: io_uart_bridge

Overview:
- Sits between the processor's IO port bus (IO_port_ID / IO_write_data / IO_read_data / strobes) and a byte-wide UART core.
- Decodes the port address space and buffers traffic in a TX FIFO and an RX FIFO.
- Sequences TX bytes to the UART under a valid/ready handshake with an enforced inter-byte gap.
- Exposes RX-present, TX-full and sticky error status to software.

Parameters:
FIFO_DEPTH, 16, entries per FIFO; power of two, 2..256
TX_GAP_CYCLES, 2, idle clocks forced between consecutive TX handshakes; 0 allowed
DATA_PORT, 8'h01, read = pop RX byte, write = push TX byte
RXSTAT_PORT, 8'h02, read = 8'hFF if RX FIFO non-empty, else 8'h00
TXSTAT_PORT, 8'h03, read = 8'hFF if TX FIFO full, else 8'h00
ERR_PORT, 8'h04, read = {5'b0, rx_overrun, tx_overflow, rx_underflow}, clear-on-read

Ports:
clk100  in  1  system clock; all state on rising edge
reset  in  1  synchronous, active-high reset
IO_port_ID  in  8  port address from processor
IO_write_data  in  8  write data from processor
IO_write_strobe  in  1  write access; may be held high for multiple cycles
IO_read_strobe  in  1  read access; may be held high for multiple cycles
IO_read_data  out  8  read data to processor
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART accepts byte when tx_valid && tx_ready
rx_data  in  8  received byte
rx_strobe  in  1  one-cycle pulse: rx_data valid; no backpressure
irq_rx  out  1  high while RX FIFO non-empty

Behaviour:
- Reset (synchronous): both FIFOs empty, pointers/counts 0, error bits 0, TX FSM in TX_IDLE, tx_valid=0, tx_data=0, irq_rx=0, IO_read_data=0, internal strobe-history flops 0.
- Reset mid-transfer: a pending TX byte is discarded; no handshake completes in the reset cycle.

IO write:
- Acts once per strobe: a push occurs only in the first cycle of a strobe (strobe=1, previous=0).
- DATA_PORT with TX not full: push IO_write_data.
- DATA_PORT with TX full: drop the byte and set tx_overflow.
- Any other port: ignored, no side effect.

IO read:
- IO_read_data is combinational from IO_port_ID and the current state whenever IO_read_strobe=1, and holds 8'h00 otherwise.
- DATA_PORT returns the RX head, or 8'h00 if RX is empty.
- Unmapped ports return 8'hFF.
- The port ID is latched in the first strobe cycle. Side effects happen in the cycle the strobe falls (strobe=0, previous=1), so data is stable for the whole strobe.
  - DATA_PORT: pop if non-empty; if empty, set rx_underflow.
  - ERR_PORT: clear all three error bits. An error event in the same cycle wins, and the bit stays set.

RX capture:
- On rx_strobe with RX not full: push rx_data.
- On rx_strobe with RX full: drop the byte and set rx_overrun.
- A push and a pop in the same cycle are both honoured; when full, the push is honoured only if a pop occurs in that cycle.

TX FSM:
- TX_IDLE: if TX FIFO non-empty, go to TX_SEND with tx_data=head and tx_valid=1 on the next cycle.
- TX_SEND: tx_valid and tx_data are held stable until tx_ready.
  - On handshake, pop the TX FIFO and drop tx_valid the next cycle.
  - Go to TX_GAP if TX_GAP_CYCLES>0, else TX_IDLE.
- TX_GAP: count TX_GAP_CYCLES cycles, then go to TX_IDLE.
- Minimum handshake spacing is TX_GAP_CYCLES+2 cycles.
- A TX push during TX_SEND never alters the presented byte.

Other rules:
- FIFO pointers wrap modulo FIFO_DEPTH.
- Occupancy counts are $clog2(FIFO_DEPTH)+1 bits wide and never exceed FIFO_DEPTH.
- irq_rx is registered and equals RX non-empty one cycle late.

Test Plan:
- Reset, then read ports 0x02, 0x03, 0x04, 0x77 -> 8'h00, 8'h00, 8'h00, 8'hFF; tx_valid=0.
- Write 0x41, 0x42 to 0x01 with tx_ready=1 and TX_GAP_CYCLES=2 -> tx_data 0x41 then 0x42, in order; handshakes 4 cycles apart.
- Hold IO_write_strobe high 5 cycles writing 0x55 -> exactly one push; one TX byte 0x55.
- With tx_ready=0, write 17 bytes (depth 16) -> port 0x03 reads 8'hFF after the 16th; port 0x04 reads 8'h02, then 8'h00 on the re-read.
- Pulse rx_strobe with 0xA5 -> irq_rx=1; 0x02 reads 8'hFF; a 3-cycle read of 0x01 returns 0xA5 throughout; afterwards 0x02 reads 8'h00.
- Read 0x01 with RX empty -> 8'h00 and 0x04 reads 8'h01. Then send 17 rx_strobes with no reads -> 0x04 reads 8'h04. Assert reset while tx_valid=1 -> tx_valid=0 on the next edge and both FIFOs empty.
